box_overlay: RTL
================

BOX_OVERLAY -- requirements
Module: box_overlay

Interface
REQ-001 SHALL have parameter NBOX, default 21: number of box table entries.
REQ-002 SHALL have parameter CW, default 10: coordinate width in bits.
REQ-003 SHALL have parameter AW, default 8: width of the box address and count ports.
REQ-004 SHALL have parameter COLW, default 4: width of the per-box colour index.
REQ-005 SHALL have parameter TH, default 1: outline thickness in pixels, 1..8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port bl_en, input, 1 bit: write strobe for the shadow table.
REQ-009 SHALL have port bl_addr, input, AW bits: shadow entry index to write.
REQ-010 SHALL have port xy, input, 4*CW bits: packed as {yn,xn,y0,x0}, with x0 in the LSBs.
REQ-011 SHALL have port bl_col, input, COLW bits: colour index of the entry being written.
REQ-012 SHALL have port bl_fill, input, 1 bit: 1 = filled box, 0 = outline.
REQ-013 SHALL have port bl_cnt, input, AW bits: number of live boxes, sampled at swap.
REQ-014 SHALL have port frame_start, input, 1 bit: one-cycle pulse that swaps shadow into active.
REQ-015 SHALL have port new_pix, input, 1 bit: qualifies x and y.
REQ-016 SHALL have port x, input, CW bits: current pixel column.
REQ-017 SHALL have port y, input, CW bits: current pixel row.
REQ-018 SHALL have port pix_valid, output, 1 bit: result strobe.
REQ-019 SHALL have port pix_draw, output, 1 bit: pixel lies on or in a live box.
REQ-020 SHALL have port pix_col, output, COLW bits: colour of the winning box.

Function
REQ-021 SHALL keep two tables, shadow and active, each holding NBOX entries of {coords, col, fill}.
REQ-022 SHALL, when bl_en=1 and bl_addr<NBOX, write {xy, bl_col, bl_fill} into shadow[bl_addr] at the clock edge; bl_addr>=NBOX is ignored.
REQ-023 SHALL, on frame_start=1, copy every shadow entry into active and load active_cnt from bl_cnt at the same edge; shadow itself is unchanged.
REQ-024 SHALL, when bl_en and frame_start coincide, let active take the pre-edge shadow contents; the write lands in shadow only and becomes visible at the next swap.
REQ-025 SHALL treat entry n as live iff n<active_cnt, its coords are not all zero, x0<=xn and y0<=yn; any other entry never hits.
REQ-026 SHALL define a fill hit as x0<=x<=xn and y0<=y<=yn.
REQ-027 SHALL define an outline hit as a fill hit AND at least one of: (x-x0)<TH, (xn-x)<TH, (y-y0)<TH, (yn-y)<TH, evaluated unsigned.
REQ-028 SHALL compute the hit mask in stage 1 from the active table, registered on new_pix=1.
REQ-029 SHALL priority-encode the stage-1 mask in stage 2, lowest index winning, and register pix_draw and pix_col.
REQ-030 SHALL give fixed latency: new_pix=1 at edge t produces pix_valid=1 at edge t+2; back-to-back new_pix yields one result per cycle.
REQ-031 SHALL set pix_col to 0 when no box hits.
REQ-032 SHALL drive pix_valid=0 when no result is due, holding pix_draw and pix_col at their last values.
REQ-033 SHALL let a swap take effect for pixels sampled after the swap edge; pixels already in the pipeline complete with the table they sampled.
REQ-034 SHALL support NBOX up to 2^AW with no change to the behaviour above.

Reset
REQ-035 SHALL, on any edge where reset=0, clear both tables to all-zero, clear active_cnt, clear both pipeline stages, and set pix_valid=0, pix_draw=0, pix_col=0.
REQ-036 SHALL give reset priority over bl_en, frame_start and new_pix; a reset asserted mid-frame discards in-flight pixels.

Verification
REQ-037 SHALL cover outline with defaults: write box 0 = (10,20)-(50,60), col 3, outline; bl_cnt=1; pulse frame_start; pixels (10,40), (30,20), (30,40), (9,40) -> pix_valid two cycles after each, with draw/col 1/3, 1/3, 0/0, 0/0 respectively.
REQ-038 SHALL cover thickness and fill: with TH=3, pixel (12,40) on the outline box draws and (13,40) does not; with box 1 filled, col 5, at (100,100)-(110,110), pixel (105,105) -> 1/5.
REQ-039 SHALL cover priority: boxes 2 and 4 overlap at a pixel, col 7 and 9 -> pix_col=7; with bl_cnt=3 the box 4 area alone -> pix_draw=0.
REQ-040 SHALL cover double buffering: after a swap, rewrite box 0 in shadow without swapping -> output still follows the old box; after frame_start it follows the new one; bl_en together with frame_start -> the new value appears only after a second swap.
REQ-041 SHALL cover degenerate and out-of-range writes: box with x0>xn -> never draws; bl_addr=NBOX -> no entry changes.
REQ-042 SHALL cover reset mid-stream: reset=0 for 1 cycle during continuous new_pix -> pix_valid=0 on the next two edges, and all boxes are gone after release even after a frame_start with bl_cnt=NBOX.

Source files
------------

// File: rtl/box_overlay.sv
// box_overlay: double-buffered rectangle overlay for a pixel stream.
// A shadow table of NBOX boxes is written through bl_*; frame_start copies
// it into the active table and latches the live-box count. Each qualified
// pixel is tested against every active box in stage 1. Stage 2 picks the
// lowest-index hit and presents draw/colour two edges after new_pix.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   bl_en        shadow write strobe
//   bl_addr      shadow entry index; indices >= NBOX are ignored
//   xy           {yn,xn,y0,x0}, with x0 in the LSBs
//   bl_col       colour index of the entry being written
//   bl_fill      1 = filled box, 0 = outline of TH pixels
//   bl_cnt       live-box count, sampled at frame_start
//   frame_start  copies shadow into active
//   new_pix      qualifies x/y
//   x, y         pixel coordinates
//   pix_valid    result strobe
//   pix_draw     pixel lies on or in a live box
//   pix_col      colour of the winning box; 0 when nothing hits
module box_overlay #(
  parameter int NBOX = 21,
  parameter int CW   = 10,
  parameter int AW   = 8,
  parameter int COLW = 4,
  parameter int TH   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bl_en,
  input  logic [AW-1:0]   bl_addr,
  input  logic [4*CW-1:0] xy,
  input  logic [COLW-1:0] bl_col,
  input  logic            bl_fill,
  input  logic [AW-1:0]   bl_cnt,
  input  logic            frame_start,
  input  logic            new_pix,
  input  logic [CW-1:0]   x,
  input  logic [CW-1:0]   y,
  output logic            pix_valid,
  output logic            pix_draw,
  output logic [COLW-1:0] pix_col
);

  logic [NBOX-1:0][4*CW-1:0] r_sh_xy, r_ac_xy;
  logic [NBOX-1:0][COLW-1:0] r_sh_col, r_ac_col, r_s1_col;
  logic [NBOX-1:0]           r_sh_fill, r_ac_fill, r_s1_mask;
  logic [NBOX-1:0]           w_hit;
  logic [AW-1:0]             r_ac_cnt;
  logic [2:1]                r_vld_pipe;
  logic                      r_draw;
  logic [COLW-1:0]           r_col;
  logic                      w_draw;
  logic [COLW-1:0]           w_col;

  // Tables. The swap copies the pre-edge shadow, so a write on the same
  // edge only lands in shadow and waits for the next swap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sh_xy   <= '0;
      r_sh_col  <= '0;
      r_sh_fill <= '0;
      r_ac_xy   <= '0;
      r_ac_col  <= '0;
      r_ac_fill <= '0;
      r_ac_cnt  <= '0;
    end else begin
      if (frame_start) begin
        r_ac_xy   <= r_sh_xy;
        r_ac_col  <= r_sh_col;
        r_ac_fill <= r_sh_fill;
        r_ac_cnt  <= bl_cnt;
      end
      // Out-of-range addresses match no entry and fall through silently.
      if (bl_en) begin
        for (int n = 0; n < NBOX; n++) begin
          if (bl_addr == AW'(n)) begin
            r_sh_xy[n]   <= xy;
            r_sh_col[n]  <= bl_col;
            r_sh_fill[n] <= bl_fill;
          end
        end
      end
    end
  end

  // Per-box hit test against the active table.
  for (genvar g = 0; g < NBOX; g++) begin : g_box
    logic [CW-1:0] w_x0, w_y0, w_xn, w_yn;
    logic          w_live, w_in, w_edge;
    assign w_x0 = r_ac_xy[g][CW-1:0];
    assign w_y0 = r_ac_xy[g][2*CW-1:CW];
    assign w_xn = r_ac_xy[g][3*CW-1:2*CW];
    assign w_yn = r_ac_xy[g][4*CW-1:3*CW];
    assign w_live = (AW'(g) < r_ac_cnt) && (r_ac_xy[g] != '0) &&
                    (w_x0 <= w_xn) && (w_y0 <= w_yn);
    assign w_in   = (x >= w_x0) && (x <= w_xn) && (y >= w_y0) && (y <= w_yn);
    // Distances are only meaningful inside the box, where none can wrap.
    assign w_edge = ((x - w_x0) < CW'(TH)) || ((w_xn - x) < CW'(TH)) ||
                    ((y - w_y0) < CW'(TH)) || ((w_yn - y) < CW'(TH));
    assign w_hit[g] = w_live && w_in && (r_ac_fill[g] || w_edge);
  end

  // Lowest index wins: walk downwards so the last assignment is the lowest.
  always_comb begin
    w_draw = |r_s1_mask;
    w_col  = '0;
    for (int n = NBOX - 1; n >= 0; n--) begin
      if (r_s1_mask[n]) w_col = r_s1_col[n];
    end
  end

  // Stage 1 captures colours along with the mask so an in-flight pixel
  // finishes with the table it sampled even if a swap follows.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_s1_mask  <= '0;
      r_s1_col   <= '0;
      r_draw     <= 1'b0;
      r_col      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], new_pix};
      if (new_pix) begin
        r_s1_mask <= w_hit;
        r_s1_col  <= r_ac_col;
      end
      if (r_vld_pipe[1]) begin
        r_draw <= w_draw;
        r_col  <= w_col;
      end
    end
  end

  assign pix_valid = r_vld_pipe[2];
  assign pix_draw  = r_draw;
  assign pix_col   = r_col;

endmodule
